// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types, defaults and round-robin pick for the ALU request arbiter
package alu_arb_pkg;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_DW        = 10;
  localparam int DEF_RW        = 9;
  localparam int DEF_TAG_DEPTH = 8;

  localparam int OP_MSB = 9;
  localparam int OP_LSB = 8;
  localparam int A_MSB  = 7;
  localparam int A_LSB  = 4;
  localparam int B_MSB  = 3;
  localparam int B_LSB  = 0;

  typedef enum logic {EMPTY, FULL} arb_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Scans up to 8 requesters starting at ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      k = (32'(ptr) + i) % n;
      if (!r.found && (i < n) && valid[k[2:0]]) begin
        r.found = 1'b1;
        r.idx   = k[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// rtl/alu_req_arbiter_if.sv - requester, ALU and result bundle for the ALU request arbiter
interface alu_req_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int DW        = 10,
  parameter int RW        = 9,
  parameter int TAG_DEPTH = 8
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      alu_data;
  logic               alu_valid;
  logic               alu_ready;
  logic [RW-1:0]      res_data;
  logic               res_valid;
  logic [RW-1:0]      out_data;
  logic [NREQ-1:0]    out_valid;
  logic [IW-1:0]      grant_id;
  logic [CW-1:0]      tag_count;
  logic               err_orphan;

  modport slave (
    input  req_data, req_valid, alu_ready, res_data, res_valid,
    output req_ready, alu_data, alu_valid, out_data, out_valid, grant_id, tag_count, err_orphan
  );

  modport master (
    output req_data, req_valid, alu_ready, res_data, res_valid,
    input  req_ready, alu_data, alu_valid, out_data, out_valid, grant_id, tag_count, err_orphan
  );
endinterface

// File: rtl/alu_tag_fifo.sv
// rtl/alu_tag_fifo.sv - in-order FIFO of requester ids awaiting ALU results
module alu_tag_fifo #(
  parameter int TW    = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [TW-1:0]              push_tag,
  input  logic                       pop,
  output logic [TW-1:0]              head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin arbiter feeding one ALU, with tag-routed results
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int RW        = DEF_RW,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  alu_req_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TAG_DEPTH) + 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  arb_state_e      state;
  logic [IW-1:0]   rr_ptr;
  logic [7:0]      valid8;
  logic [2:0]      ptr3;
  rr_pick_t        pick;
  logic [IW-1:0]   win;
  logic            can_load;
  logic            load;
  logic [DW-1:0]   alu_data_q;
  logic [IW-1:0]   grant_q;
  logic [RW-1:0]   out_data_q;
  logic [NREQ-1:0] out_valid_q;
  logic            err_orphan_q;
  logic [IW-1:0]   tag_head;
  logic [CW-1:0]   tag_count;
  logic            tag_full;
  logic            tag_empty;
  logic            tag_pop;

  always_comb begin
    valid8            = '0;
    valid8[NREQ-1:0]  = bus.req_valid;
    ptr3              = '0;
    ptr3[IW-1:0]      = rr_ptr;
  end

  assign pick     = rr_pick(valid8, ptr3, NREQ);
  assign win      = pick.idx[IW-1:0];
  // Full tag FIFO blocks loading even when a pop lands in the same cycle.
  assign can_load = ((state == EMPTY) || bus.alu_ready) && !tag_full;
  assign load     = can_load && pick.found && !reset;
  assign tag_pop  = bus.res_valid && !tag_empty;

  assign bus.req_ready  = load ? (ONE << win) : '0;
  assign bus.alu_valid  = (state == FULL);
  assign bus.alu_data   = alu_data_q;
  assign bus.grant_id   = grant_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.tag_count  = tag_count;
  assign bus.err_orphan = err_orphan_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= EMPTY;
      rr_ptr       <= '0;
      alu_data_q   <= '0;
      grant_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      if (load) begin
        alu_data_q <= bus.req_data[win*DW +: DW];
        grant_q    <= win;
        state      <= FULL;
        rr_ptr     <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
      end else if ((state == FULL) && bus.alu_ready) begin
        state <= EMPTY;
      end
      out_valid_q <= tag_pop ? (ONE << tag_head) : '0;
      if (tag_pop) out_data_q <= bus.res_data;
      if (bus.res_valid && tag_empty) err_orphan_q <= 1'b1;
    end
  end

  alu_tag_fifo #(
    .TW    (IW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (load),
    .push_tag (win),
    .pop      (tag_pop),
    .head     (tag_head),
    .count    (tag_count),
    .full     (tag_full),
    .empty    (tag_empty)
  );
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed self-checking bench for alu_req_arbiter
module tb_alu_req_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  alu_req_arbiter_if bus ();

  alu_req_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [9:0] d);
    bus.req_data[i*10 +: 10] = d;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.res_valid = 1'b0;
    bus.alu_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [3:0] oh(input int g);
    logic [3:0] one;
    one = 4'b0001;
    return one << g;
  endfunction

  logic [9:0] rrd [4];
  int         ord [8];

  initial begin
    rrd = '{10'h110, 10'h232, 10'h140, 10'h250};
    reset         = 1'b1;
    bus.req_data  = '0;
    bus.req_valid = 4'b1111;
    bus.alu_ready = 1'b1;
    bus.res_data  = '0;
    bus.res_valid = 1'b0;
    tick();
    tick();
    chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
    chk("reset_alu_valid", 32'(bus.alu_valid), 32'h0);
    chk("reset_alu_data", 32'(bus.alu_data), 32'h0);
    chk("reset_grant", 32'(bus.grant_id), 32'h0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_out_data", 32'(bus.out_data), 32'h0);
    chk("reset_tag_count", 32'(bus.tag_count), 32'h0);
    chk("reset_err", 32'(bus.err_orphan), 32'h0);
    do_reset();

    // Single request and result routing
    set_req(0, 10'h151);
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    chk("t1_alu_valid", 32'(bus.alu_valid), 32'h1);
    chk("t1_alu_data", 32'(bus.alu_data), 32'h151);
    chk("t1_grant", 32'(bus.grant_id), 32'h0);
    chk("t1_tag_count", 32'(bus.tag_count), 32'h1);
    tick();
    chk("t1_alu_drained", 32'(bus.alu_valid), 32'h0);
    bus.res_data  = 9'h006;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    chk("t1_out_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_out_data", 32'(bus.out_data), 32'h006);
    chk("t1_tag_count0", 32'(bus.tag_count), 32'h0);
    tick();
    chk("t1_out_pulse", 32'(bus.out_valid), 32'h0);

    // Round robin with all four requesting, then only 2 and 0 from ptr=1
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, rrd[i]);
    bus.req_valid = 4'b1111;
    ord = '{0, 1, 2, 3, 0, 2, 0, 0};
    for (int k = 0; k < 7; k++) begin
      if (k == 5) bus.req_valid = 4'b0101;
      #1;
      chk($sformatf("rr_ready_%0d", k), 32'(bus.req_ready), 32'(oh(ord[k])));
      tick();
      chk($sformatf("rr_grant_%0d", k), 32'(bus.grant_id), 32'(ord[k]));
      chk($sformatf("rr_data_%0d", k), 32'(bus.alu_data), 32'(rrd[ord[k]]));
    end
    bus.req_valid = '0;
    chk("rr_tag_count", 32'(bus.tag_count), 32'd7);

    // Backpressure holds the output register
    do_reset();
    set_req(0, 10'h330);
    set_req(1, 10'h0AB);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0010;
    bus.alu_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_ready_%0d", k), 32'(bus.req_ready), 32'h0);
      chk($sformatf("bp_data_%0d", k), 32'(bus.alu_data), 32'h330);
      chk($sformatf("bp_valid_%0d", k), 32'(bus.alu_valid), 32'h1);
      tick();
    end
    bus.alu_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    chk("bp_next_data", 32'(bus.alu_data), 32'h0AB);
    chk("bp_next_grant", 32'(bus.grant_id), 32'h1);

    // Tag FIFO full blocks loading until the cycle after a pop
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, rrd[i]);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) tick();
    chk("full_tag_count", 32'(bus.tag_count), 32'd8);
    chk("full_last_grant", 32'(bus.grant_id), 32'd3);
    #1;
    chk("full_blocked", 32'(bus.req_ready), 32'h0);
    tick();
    chk("full_drained", 32'(bus.alu_valid), 32'h0);
    bus.res_data  = 9'h0A5;
    bus.res_valid = 1'b1;
    #1;
    chk("full_pop_blocked", 32'(bus.req_ready), 32'h0);
    tick();
    bus.res_valid = 1'b0;
    chk("full_out_valid", 32'(bus.out_valid), 32'h1);
    chk("full_out_data", 32'(bus.out_data), 32'h0A5);
    chk("full_after_pop", 32'(bus.tag_count), 32'd7);
    #1;
    chk("full_resume_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    chk("full_resume_grant", 32'(bus.grant_id), 32'd0);
    chk("full_refill", 32'(bus.tag_count), 32'd8);

    // Orphan result is sticky
    do_reset();
    bus.res_data  = 9'h1FF;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    chk("orphan_out_valid", 32'(bus.out_valid), 32'h0);
    chk("orphan_err", 32'(bus.err_orphan), 32'h1);
    tick();
    tick();
    chk("orphan_sticky", 32'(bus.err_orphan), 32'h1);

    // Reset mid-flight discards command and tags
    do_reset();
    chk("mid_err_cleared", 32'(bus.err_orphan), 32'h0);
    bus.req_valid = 4'b0111;
    tick();
    tick();
    tick();
    bus.req_valid = '0;
    chk("mid_tag_count", 32'(bus.tag_count), 32'd3);
    chk("mid_alu_data", 32'(bus.alu_data), 32'h140);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.alu_valid), 32'h0);
    chk("mid_rst_data", 32'(bus.alu_data), 32'h0);
    chk("mid_rst_grant", 32'(bus.grant_id), 32'h0);
    chk("mid_rst_tags", 32'(bus.tag_count), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    bus.res_data  = 9'h055;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    chk("mid_post_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_post_err", 32'(bus.err_orphan), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
